brent_kung: RTL and testbench

Parameterised Brent-Kung parallel-prefix adder computing {Cout, S} = A + B + Cin over WIDTH bits, with WIDTH defaulting to 16. By default the datapath is purely combinational, for use inside arithmetic units where carry-chain depth matters. An optional output register gives a one-cycle registered variant on the shared clock and reset.

---
 rtl/brent_kung_pkg.sv | 21 ++
 rtl/brent_kung_if.sv | 16 +
 rtl/brent_kung_prefix_cell.sv | 15 +
 rtl/brent_kung.sv | 109 ++++++++++
 tb/tb_brent_kung.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/brent_kung_pkg.sv
// rtl/brent_kung_pkg.sv - shared constants and tree-depth helpers for the Brent-Kung adder
package brent_kung_pkg;

    localparam int BK_DEFAULT_WIDTH = 16;

    // Ceiling log2, used to size the up-sweep tree.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Total prefix levels: log2(W) up-sweep plus log2(W)-1 down-sweep.
    function automatic int bk_levels(input int width);
        return 2 * clog2(width) - 1;
    endfunction

endpackage

// File: rtl/brent_kung_if.sv
// rtl/brent_kung_if.sv - operand/result bundle for the Brent-Kung adder
interface brent_kung_if
    import brent_kung_pkg::*;
#(
    parameter int WIDTH = BK_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (output A, output B, output Cin, input S, input Cout);
    modport slave  (input A, input B, input Cin, output S, output Cout);

endinterface

// File: rtl/brent_kung_prefix_cell.sv
// rtl/brent_kung_prefix_cell.sv - (G,P) prefix operator, high combined over low
module bk_prefix_cell (
    input  logic i_gh,
    input  logic i_ph,
    input  logic i_gl,
    input  logic i_pl,
    output logic o_g,
    output logic o_p
);

    // Black cell; a gray cell is this same cell with o_p ignored downstream.
    assign o_g = i_gh | (i_ph & i_gl);
    assign o_p = i_ph & i_pl;

endmodule

// File: rtl/brent_kung.sv
// rtl/brent_kung.sv - Brent-Kung parallel-prefix adder with optional output register
module brent_kung
    import brent_kung_pkg::*;
#(
    parameter int WIDTH        = BK_DEFAULT_WIDTH,
    parameter bit REGISTER_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    brent_kung_if.slave bus
);

    localparam int LOG_W = clog2(WIDTH);
    localparam int N_LEV = bk_levels(WIDTH);

    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_unused_p;

    // Bit generate/propagate; Cin is folded into bit 0 so every G[i:0] is a true carry.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit0
        assign w_p0[i] = bus.A[i] ^ bus.B[i];
        if (i == 0) begin : g_fold
            assign w_g0[i] = (bus.A[i] & bus.B[i]) | ((bus.A[i] ^ bus.B[i]) & bus.Cin);
        end else begin : g_plain
            assign w_g0[i] = bus.A[i] & bus.B[i];
        end
    end

    // Levels 1..LOG_W are the up-sweep, the rest the down-sweep. Each level owns
    // its own vectors so no signal feeds back into itself.
    for (genvar l = 1; l <= N_LEV; l++) begin : g_lev
        localparam bit UP = (l <= LOG_W);
        localparam int K  = UP ? l : (2 * LOG_W - l);

        logic [WIDTH-1:0] w_gin;
        logic [WIDTH-1:0] w_pin;
        logic [WIDTH-1:0] w_gout;
        logic [WIDTH-1:0] w_pout;

        if (l == 1) begin : g_first
            assign w_gin = w_g0;
            assign w_pin = w_p0;
        end else begin : g_next
            assign w_gin = g_lev[l-1].w_gout;
            assign w_pin = g_lev[l-1].w_pout;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            // Up-sweep: nodes at 2^K-1 mod 2^K. Down-sweep: nodes halfway
            // between completed prefixes, above the first full block.
            localparam bit IS_CELL = UP ?
                (((i + 1) % (1 << K)) == 0) :
                ((((i + 1) % (1 << K)) == (1 << (K - 1))) && (i >= (1 << K)));

            if (IS_CELL) begin : g_cell
                bk_prefix_cell u_cell (
                    .i_gh (w_gin[i]),
                    .i_ph (w_pin[i]),
                    .i_gl (w_gin[i - (1 << (K - 1))]),
                    .i_pl (w_pin[i - (1 << (K - 1))]),
                    .o_g  (w_gout[i]),
                    .o_p  (w_pout[i])
                );
            end else begin : g_pass
                assign w_gout[i] = w_gin[i];
                assign w_pout[i] = w_pin[i];
            end
        end
    end

    // After the last level every node holds G[i:0], i.e. the carry into bit i+1.
    assign w_c[0]       = bus.Cin;
    assign w_c[WIDTH:1] = g_lev[N_LEV].w_gout;
    assign w_sum        = w_p0 ^ w_c[WIDTH-1:0];
    assign w_cout       = w_c[WIDTH];

    // Group propagates of finished prefixes are never needed.
    assign w_unused_p = ^g_lev[N_LEV].w_pout;

    if (REGISTER_OUT) begin : g_reg
        logic [WIDTH-1:0] r_s;
        logic             r_cout;

        // Register the sum; reset takes priority over new data.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s    <= '0;
                r_cout <= 1'b0;
            end else begin
                r_s    <= w_sum;
                r_cout <= w_cout;
            end
        end

        assign bus.S    = r_s;
        assign bus.Cout = r_cout;
    end else begin : g_comb
        logic w_unused_clk_rst;

        assign w_unused_clk_rst = clk ^ rst;
        assign bus.S            = w_sum;
        assign bus.Cout         = w_cout;
    end

endmodule

// File: tb/tb_brent_kung.sv
// tb/tb_brent_kung.sv - self-checking bench for the Brent-Kung adder
module tb_brent_kung;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    logic [15:0] vec [0:99];
    logic [15:0] ra, rb;
    logic        rcin;
    logic [31:0] rexp;

    brent_kung_if #(.WIDTH(16)) if_c16 ();
    brent_kung_if #(.WIDTH(16)) if_r16 ();
    brent_kung_if #(.WIDTH(8))  if_c8  ();

    brent_kung #(.WIDTH(16), .REGISTER_OUT(1'b0)) u_c16 (
        .clk (clk),
        .rst (rst),
        .bus (if_c16.slave)
    );

    brent_kung #(.WIDTH(16), .REGISTER_OUT(1'b1)) u_r16 (
        .clk (clk),
        .rst (rst),
        .bus (if_r16.slave)
    );

    brent_kung #(.WIDTH(8), .REGISTER_OUT(1'b0)) u_c8 (
        .clk (clk),
        .rst (rst),
        .bus (if_c8.slave)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [31:0] ref_sum(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
        return a + b + c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply_c16(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic cin);
        if_c16.A   = a;
        if_c16.B   = b;
        if_c16.Cin = cin;
        #20;
        check(tag, {15'd0, if_c16.Cout, if_c16.S}, ref_sum(a, b, cin));
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        if_c16.A   = '0;
        if_c16.B   = '0;
        if_c16.Cin = 1'b0;
        if_r16.A   = '0;
        if_r16.B   = '0;
        if_r16.Cin = 1'b0;
        if_c8.A    = '0;
        if_c8.B    = '0;
        if_c8.Cin  = 1'b0;
        #5;

        apply_c16("zero",        16'h0000, 16'h0000, 1'b0);
        apply_c16("no_carry",    16'h1234, 16'h4321, 1'b0);
        apply_c16("ripple_b",    16'hFFFF, 16'h0001, 1'b0);
        apply_c16("ripple_cin",  16'hFFFF, 16'h0000, 1'b1);
        apply_c16("max",         16'hFFFF, 16'hFFFF, 1'b1);
        apply_c16("msb_carry",   16'h8000, 16'h8000, 1'b0);

        vec[0] = 16'h0000;
        vec[1] = 16'hFFFF;
        vec[2] = 16'h8000;
        vec[3] = 16'h0001;
        vec[4] = 16'h7FFF;
        vec[5] = 16'h5555;
        for (int i = 6; i < 100; i++) begin
            vec[i] = 16'($urandom);
        end

        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 100; i++) begin
                for (int j = 0; j < 100; j++) begin
                    apply_c16("xprod", vec[i], vec[j], c[0]);
                end
            end
        end

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reg_reset", {15'd0, if_r16.Cout, if_r16.S}, 32'd0);

        rst        = 1'b0;
        if_r16.A   = 16'h00FF;
        if_r16.B   = 16'h0001;
        if_r16.Cin = 1'b0;
        @(negedge clk);
        check("reg_first", {15'd0, if_r16.Cout, if_r16.S}, 32'h0000_0100);

        for (int n = 0; n < 50; n++) begin
            ra         = 16'($urandom);
            rb         = 16'($urandom);
            rcin       = 1'($urandom);
            if_r16.A   = ra;
            if_r16.B   = rb;
            if_r16.Cin = rcin;
            rexp       = ref_sum(ra, rb, rcin);
            @(negedge clk);
            check("reg_stream", {15'd0, if_r16.Cout, if_r16.S}, rexp);
        end

        ra         = 16'hFFFF;
        rb         = 16'hFFFF;
        rcin       = 1'b1;
        if_r16.A   = ra;
        if_r16.B   = rb;
        if_r16.Cin = rcin;
        rst        = 1'b1;
        @(negedge clk);
        check("reg_rst_prio", {15'd0, if_r16.Cout, if_r16.S}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reg_after_rst", {15'd0, if_r16.Cout, if_r16.S}, ref_sum(ra, rb, rcin));

        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 256; a++) begin
                for (int b = 0; b < 256; b++) begin
                    if_c8.A   = a[7:0];
                    if_c8.B   = b[7:0];
                    if_c8.Cin = c[0];
                    #1;
                    check("exh8", {23'd0, if_c8.Cout, if_c8.S}, ref_sum(a, b, c));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
